dcache_nway: RTL and testbench

Parametrised N-way set-associative, write-through, no-write-allocate data cache sitting between the memory-stage ALU address and the data memory in the pipelined CPU. It answers read hits combinationally and, on read miss or any write, raises a stall that freezes every pipeline register and the PC until the access completes. Ways, sets and line length are parameters. Replacement is round-robin per set with invalid-way preference, and the block keeps saturating hit/miss counters.

---
 rtl/dcache_nway.sv | 216 +++++++++++++++++++++
 tb/tb_dcache_nway.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-through, no-write-allocate data cache.
// Read hits are answered combinationally. Read misses and all writes stall the
// pipeline until the memory side completes. Replacement is round-robin per set,
// preferring the lowest invalid way. Saturating read hit/miss counters.
module dcache_nway #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int WAYS       = 2,
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_i,
   input  logic            we_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DW-1:0]   wdata_i,
   input  logic [DW/8-1:0] be_i,
   input  logic            flush_i,
   output logic [DW-1:0]   rdata_o,
   output logic            stall_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_be_o,
   input  logic            mem_ack_i,
   input  logic [DW-1:0]   mem_rdata_i,
   output logic [31:0]     hit_cnt_o,
   output logic [31:0]     miss_cnt_o
);

   localparam int BYTES = DW / 8;
   localparam int BO    = $clog2(BYTES);
   localparam int OB    = $clog2(LINE_WORDS);
   localparam int IW    = $clog2(SETS);
   localparam int TW    = AW - BO - OB - IW;
   localparam int OW    = (OB > 0) ? OB : 1;
   localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [AW-1:0] WORD_MASK = AW'(BYTES - 1);
   localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS * BYTES - 1);

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

   state_t            state_q;
   logic [SETS-1:0]   valid_q [WAYS];
   logic [TW-1:0]     tag_q   [WAYS][SETS];
   logic [DW-1:0]     data_q  [WAYS][SETS][LINE_WORDS];
   logic [VW-1:0]     ptr_q   [SETS];

   // Latched context of the access being serviced.
   logic [VW-1:0]     r_way;
   logic [IW-1:0]     r_idx;
   logic [OW-1:0]     r_off;
   logic [TW-1:0]     r_tag;
   logic              r_hit;
   logic              r_we;
   logic              r_full;
   logic [OW-1:0]     cnt_q;

   // Address fields of the incoming request.
   logic [OW-1:0]     a_off;
   logic [IW-1:0]     a_idx;
   logic [TW-1:0]     a_tag;
   assign a_off = (LINE_WORDS > 1) ? OW'(addr_i >> BO) : '0;
   assign a_idx = IW'(addr_i >> (BO + OB));
   assign a_tag = TW'(addr_i >> (BO + OB + IW));

   logic              hit;
   logic [VW-1:0]     hit_way;
   logic [VW-1:0]     vict_way;
   logic              full;

   // Tag lookup and victim choice for the addressed set.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
      hit      = 1'b0;
      hit_way  = '0;
      vict_way = ptr_q[a_idx];
      full     = 1'b1;
      // Descending scan so the lowest matching / lowest invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[w][a_idx] && tag_q[w][a_idx] == a_tag) begin
            hit     = 1'b1;
            hit_way = VW'(w);
         end
         if (!valid_q[w][a_idx]) begin
            full     = 1'b0;
            vict_way = VW'(w);
         end
      end
   end

   logic is_idle;
   logic rd_hit;
   logic mem_ack;
   logic last_word;
   assign is_idle   = (state_q == IDLE);
   assign rd_hit    = is_idle && req_i && !we_i && !flush_i && hit;
   assign mem_ack   = mem_req_o && mem_ack_i;
   assign last_word = (cnt_q == OW'(LINE_WORDS - 1));

   assign stall_o = rst && ((is_idle && (flush_i || (req_i && (we_i || !hit))))
                            || state_q == REFILL || state_q == WRITE);

   // Read data: hit word in IDLE, refilled word in DONE, zero otherwise.
   always_comb begin
      rdata_o = '0;
      if (rst) begin
         if (rd_hit)
            rdata_o = data_q[hit_way][a_idx][a_off];
         else if (state_q == DONE && !r_we)
            rdata_o = data_q[r_way][r_idx][r_off];
      end
   end

   // Control FSM, valid bits, victim pointers, registered memory port and counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
         for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
         r_way       <= '0;
         r_idx       <= '0;
         r_off       <= '0;
         r_tag       <= '0;
         r_hit       <= 1'b0;
         r_we        <= 1'b0;
         r_full      <= 1'b0;
         cnt_q       <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush_i) begin
                  for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                  for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
               end else if (req_i) begin
                  r_idx <= a_idx;
                  r_off <= a_off;
                  r_we  <= we_i;
                  if (we_i) begin
                     r_hit       <= hit;
                     r_way       <= hit_way;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= 1'b1;
                     mem_addr_o  <= addr_i & ~WORD_MASK;
                     mem_wdata_o <= wdata_i;
                     mem_be_o    <= be_i;
                     state_q     <= WRITE;
                  end else if (hit) begin
                     if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
                  end else begin
                     if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
                     r_way       <= vict_way;
                     r_full      <= full;
                     r_tag       <= a_tag;
                     cnt_q       <= '0;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= 1'b0;
                     mem_addr_o  <= addr_i & ~LINE_MASK;
                     mem_wdata_o <= '0;
                     mem_be_o    <= '0;
                     state_q     <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  if (last_word) begin
                     valid_q[r_way][r_idx] <= 1'b1;
                     if (r_full)
                        ptr_q[r_idx] <= (WAYS > 1) ? ptr_q[r_idx] + VW'(1) : '0;
                     cnt_q     <= '0;
                     mem_req_o <= 1'b0;
                     state_q   <= DONE;
                  end else begin
                     cnt_q      <= cnt_q + OW'(1);
                     mem_addr_o <= mem_addr_o + AW'(BYTES);
                  end
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  state_q   <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data arrays: refill fill-in and write-hit byte merge.
   // NOTE: the arrays carry no reset; valid bits alone decide whether their contents are used.
   always_ff @(posedge clk) begin
      if (state_q == REFILL && mem_ack) begin
         data_q[r_way][r_idx][cnt_q] <= mem_rdata_i;
         if (last_word) tag_q[r_way][r_idx] <= r_tag;
      end
      if (state_q == WRITE && mem_ack && r_hit) begin
         for (int b = 0; b < BYTES; b++)
            if (mem_be_o[b]) data_q[r_way][r_idx][r_off][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end
   end

endmodule

// File: tb/tb_dcache_nway.sv
// Testbench for dcache_nway: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a line-level reference model.
module tb_dcache_nway;

   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we, flush;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] hit_cnt, miss_cnt;

   int checks = 0;
   int errors = 0;

   dcache_nway #(.DW(32), .AW(32), .WAYS(2), .SETS(4), .LINE_WORDS(4)) dut (
      .clk(clk), .rst(rst_n),
      .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be), .flush_i(flush),
      .rdata_o(rdata), .stall_o(stall),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
      .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- memory model: mem[a] = a ^ KEY until written ----------------
   logic [31:0] mem_q [logic [31:0]];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_q.exists(a)) return mem_q[a];
      return a ^ KEY;
   endfunction

   function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      logic [31:0] cur;
      cur = mem_read(a);
      for (int i = 0; i < 4; i++) if (b[i]) cur[i*8 +: 8] = d[i*8 +: 8];
      mem_q[a] = cur;
   endfunction

   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          ack_total = 0;
   int          addr_moved = 0;
   int          wr_count = 0;
   logic [31:0] held_addr = '0;
   logic [31:0] rd_log [$];
   logic [31:0] wr_addr = '0, wr_data = '0;
   logic [3:0]  wr_be = '0;

   // Memory responder: acks after ack_delay wait cycles, decided on the falling edge.
   always @(negedge clk) begin
      if (!rst_n || !mem_req) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else begin
         if (wait_cnt > 0 && mem_addr != held_addr) addr_moved++;
         if (wait_cnt == 0) held_addr = mem_addr;
         if (wait_cnt == ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem_write(mem_addr, mem_wdata, mem_be);
               wr_addr = mem_addr; wr_data = mem_wdata; wr_be = mem_be;
               wr_count++;
            end else begin
               mem_rdata = mem_read(mem_addr);
               rd_log.push_back(mem_addr);
            end
            ack_total++;
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end
   end

   // ---------------- CPU-side access helpers (called at posedge+1) ----------------
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, output int st, output logic [31:0] rd);
      bit done;
      done = 0;
      req = 1'b1; we = w; addr = a; wdata = wd; be = b;
      st = 0; rd = '0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (stall) st++;
         else begin rd = rdata; done = 1; end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL access_timeout: addr %h still stalled after 300 cycles", a);
      end
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic do_flush(output logic st);
      flush = 1'b1;
      @(negedge clk);
      st = stall;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic check_refill(input string name, input logic [31:0] a);
      check({name, " nreads"}, 32'(rd_log.size()), 32'd4);
      if (rd_log.size() == 4)
         for (int k = 0; k < 4; k++)
            check($sformatf("%s read%0d addr", name, k), rd_log[k], (a & ~32'hF) + 32'(4 * k));
   endtask

   // ---------------- reference model: lines held per set, round-robin victim ----------------
   logic        m_valid [4][2];
   logic [31:0] m_line  [4][2];
   int          m_ptr   [4];

   function automatic void model_clear();
      for (int s = 0; s < 4; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
      end
   endfunction

   // Returns 1 on hit; on miss installs the line where the cache should put it.
   function automatic bit model_read(input logic [31:0] a);
      int s;
      logic [31:0] line;
      line = a >> 4;
      s = int'(line % 4);
      for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_line[s][w] == line) return 1;
      for (int w = 0; w < 2; w++)
         if (!m_valid[s][w]) begin
            m_valid[s][w] = 1'b1; m_line[s][w] = line;
            return 0;
         end
      m_line[s][m_ptr[s]] = line;
      m_ptr[s] = (m_ptr[s] + 1) % 2;
      return 0;
   endfunction

   // ---------------- directed vector table ----------------
   typedef enum logic [1:0] {OP_RD, OP_WR, OP_FL} op_e;
   typedef struct {
      op_e         op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          stalls;
      logic [31:0] rdata;
      int          hits;
      int          misses;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int          st;
      logic        st1;
      logic [31:0] rd;
      int          wc0;
      int          base;
      int          h0, m0, mh, mm;

      vecs[0]  = '{OP_RD, 32'h100, 32'h0, 4'h0, 5, 32'h100 ^ KEY, 0, 1};
      vecs[1]  = '{OP_RD, 32'h108, 32'h0, 4'h0, 0, 32'h108 ^ KEY, 1, 1};
      vecs[2]  = '{OP_FL, 32'h0,   32'h0, 4'h0, 1, 32'h0,         1, 1};
      vecs[3]  = '{OP_RD, 32'h000, 32'h0, 4'h0, 5, 32'h000 ^ KEY, 1, 2};
      vecs[4]  = '{OP_RD, 32'h040, 32'h0, 4'h0, 5, 32'h040 ^ KEY, 1, 3};
      vecs[5]  = '{OP_RD, 32'h080, 32'h0, 4'h0, 5, 32'h080 ^ KEY, 1, 4};
      vecs[6]  = '{OP_RD, 32'h040, 32'h0, 4'h0, 0, 32'h040 ^ KEY, 2, 4};
      vecs[7]  = '{OP_RD, 32'h000, 32'h0, 4'h0, 5, 32'h000 ^ KEY, 2, 5};
      vecs[8]  = '{OP_RD, 32'h100, 32'h0, 4'h0, 5, 32'h100 ^ KEY, 2, 6};
      vecs[9]  = '{OP_WR, 32'h104, 32'hDEADBEEF, 4'b0011, 2, 32'h0, 2, 6};
      vecs[10] = '{OP_RD, 32'h104, 32'h0, 4'h0, 0, 32'hA5A5BEEF,   3, 6};
      vecs[11] = '{OP_WR, 32'h300, 32'h12345678, 4'b1111, 2, 32'h0, 3, 6};
      vecs[12] = '{OP_RD, 32'h300, 32'h0, 4'h0, 5, 32'h12345678,   3, 7};
      vecs[13] = '{OP_RD, 32'h104, 32'h0, 4'h0, 0, 32'hA5A5BEEF,   4, 7};

      rst_n = 1'b0; req = 1'b0; we = 1'b0; flush = 1'b0;
      addr = '0; wdata = '0; be = '0;
      mem_ack = 1'b0; mem_rdata = '0;

      // Reset state
      #3;
      check("reset stall", 32'(stall), 32'd0);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset mem_be", 32'(mem_be), 32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset hit_cnt", hit_cnt, 32'd0);
      check("reset miss_cnt", miss_cnt, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table, zero-wait memory
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].op == OP_FL) begin
            do_flush(st1);
            check($sformatf("v%0d flush stall", i), 32'(st1), 32'(vecs[i].stalls));
         end else begin
            rd_log.delete();
            wc0 = wr_count;
            access(vecs[i].op == OP_WR, vecs[i].addr, vecs[i].wdata, vecs[i].be, st, rd);
            check($sformatf("v%0d stalls", i), 32'(st), 32'(vecs[i].stalls));
            check($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
            if (vecs[i].op == OP_WR) begin
               check($sformatf("v%0d nwrites", i), 32'(wr_count - wc0), 32'd1);
               check($sformatf("v%0d wr_addr", i), wr_addr, vecs[i].addr & ~32'h3);
               check($sformatf("v%0d wr_data", i), wr_data, vecs[i].wdata);
               check($sformatf("v%0d wr_be", i), 32'(wr_be), 32'(vecs[i].be));
            end else if (vecs[i].stalls == 0) begin
               check($sformatf("v%0d nreads", i), 32'(rd_log.size()), 32'd0);
            end else begin
               check_refill($sformatf("v%0d", i), vecs[i].addr);
            end
         end
         check($sformatf("v%0d hit_cnt", i), hit_cnt, 32'(vecs[i].hits));
         check($sformatf("v%0d miss_cnt", i), miss_cnt, 32'(vecs[i].misses));
      end

      // Slow memory: 3 wait cycles per word on a refill and on a write
      ack_delay = 3;
      addr_moved = 0;
      rd_log.delete();
      access(1'b0, 32'h240, 32'h0, 4'h0, st, rd);
      check("slow read stalls", 32'(st), 32'd17);
      check("slow read rdata", rd, 32'h240 ^ KEY);
      check("slow read addr stable", 32'(addr_moved), 32'd0);
      check_refill("slow read", 32'h240);
      access(1'b1, 32'h304, 32'h0BADF00D, 4'hF, st, rd);
      check("slow write stalls", 32'(st), 32'd5);
      check("slow write addr stable", 32'(addr_moved), 32'd0);
      ack_delay = 0;
      access(1'b0, 32'h304, 32'h0, 4'h0, st, rd);
      check("write hit reread stalls", 32'(st), 32'd0);
      check("write hit reread rdata", rd, 32'h0BADF00D);
      check("after slow hit_cnt", hit_cnt, 32'd5);
      check("after slow miss_cnt", miss_cnt, 32'd8);

      // Reset in the middle of a refill, after two words
      base = ack_total;
      req = 1'b1; we = 1'b0; addr = 32'h340;
      for (int c = 0; c < 50 && ack_total < base + 2; c++) @(posedge clk);
      #1;
      check("midrefill acks", 32'(ack_total - base), 32'd2);
      check("midrefill req before reset", 32'(mem_req), 32'd1);
      rst_n = 1'b0; req = 1'b0;
      #1;
      check("midrefill mem_req", 32'(mem_req), 32'd0);
      check("midrefill stall", 32'(stall), 32'd0);
      check("midrefill mem_addr", mem_addr, 32'd0);
      check("midrefill hit_cnt", hit_cnt, 32'd0);
      check("midrefill miss_cnt", miss_cnt, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      rd_log.delete();
      access(1'b0, 32'h340, 32'h0, 4'h0, st, rd);
      check("post reset stalls", 32'(st), 32'd5);
      check("post reset rdata", rd, 32'h340 ^ KEY);
      check_refill("post reset", 32'h340);
      check("post reset miss_cnt", miss_cnt, 32'd1);

      // Flush with a same-cycle request: one flush stall, then a full miss
      req = 1'b1; we = 1'b0; addr = 32'h348;
      do_flush(st1);
      check("flush+req stall", 32'(st1), 32'd1);
      check("flush+req no hit counted", hit_cnt, 32'd0);
      rd_log.delete();
      access(1'b0, 32'h348, 32'h0, 4'h0, st, rd);
      check("flush+req stalls", 32'(st), 32'd5);
      check("flush+req rdata", rd, 32'h348 ^ KEY);
      check_refill("flush+req", 32'h348);
      check("flush+req miss_cnt", miss_cnt, 32'd2);

      // Randomized traffic against the reference model
      do_flush(st1);
      model_clear();
      h0 = int'(hit_cnt); m0 = int'(miss_cnt); mh = 0; mm = 0;
      for (int n = 0; n < 400; n++) begin
         int          r;
         logic [31:0] a, wd, exp_d;
         logic [3:0]  b;
         bit          h;
         r = int'($urandom_range(0, 99));
         ack_delay = int'($urandom_range(0, 2));
         a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
         if (r < 5) begin
            do_flush(st1);
            model_clear();
            check($sformatf("r%0d flush stall", n), 32'(st1), 32'd1);
         end else if (r < 40) begin
            wd = $urandom;
            b  = 4'($urandom_range(0, 15));
            wc0 = wr_count;
            access(1'b1, a, wd, b, st, rd);
            check($sformatf("r%0d wr stalls", n), 32'(st), 32'(ack_delay + 2));
            check($sformatf("r%0d wr rdata", n), rd, 32'd0);
            check($sformatf("r%0d nwrites", n), 32'(wr_count - wc0), 32'd1);
            check($sformatf("r%0d wr_addr", n), wr_addr, a & ~32'h3);
            check($sformatf("r%0d wr_data", n), wr_data, wd);
            check($sformatf("r%0d wr_be", n), 32'(wr_be), 32'(b));
         end else begin
            exp_d = mem_read(a & ~32'h3);
            h = model_read(a);
            if (h) mh++; else mm++;
            access(1'b0, a, 32'h0, 4'h0, st, rd);
            check($sformatf("r%0d rd stalls", n), 32'(st), h ? 32'd0 : 32'(1 + 4 * (ack_delay + 1)));
            check($sformatf("r%0d rdata", n), rd, exp_d);
         end
      end
      ack_delay = 0;
      check("random hit_cnt", hit_cnt, 32'(h0 + mh));
      check("random miss_cnt", miss_cnt, 32'(m0 + mm));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
